aes_ctrl: RTL
=============

AES_CTRL -- requirements
Module: aes_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: clk input 1, rising-edge clock; nrst input 1, reset, synchronous and active-low.
REQ-002 run_i input 1 SHALL be the start request, sampled only in IDLE.
REQ-003 opcode_i input 1 SHALL select the operation (1 = encrypt, 0 = key expansion only) and SHALL be latched when run_i is accepted.
REQ-004 en output 1 SHALL be the register-update enable for aes_enc.
REQ-005 gen_key output 1 SHALL make aes_key_gen load key_i into its key register.
REQ-006 next_rnd output 1 SHALL make aes_key_gen commit the computed next round key at the clock edge.
REQ-007 r_con_ctrl output 8 (aes_pkg::aes_byte) SHALL carry the current round constant.
REQ-008 key_gen output 1 SHALL select the key path of aes_sbox (1) or the data path (0).
REQ-009 zero_rnd, full_enc and final_rnd output 1 each SHALL mark the initial AddRoundKey, rounds 1-9 and round 10 respectively.
REQ-010 rnd_o output 4 SHALL expose the current round number, 0-10.
REQ-011 key_ready_o output 1 SHALL pulse for one cycle when a key expansion completes.
REQ-012 cipher_ready_o output 1 SHALL pulse for one cycle when an encryption completes.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, ZERO, KEY, DATA and DONE; all outputs SHALL be decoded from registered state, round counter and latched opcode.
REQ-014 IDLE: all outputs SHALL be 0 and r_con_ctrl 0x00; run_i=1 SHALL go to ZERO with round=0.
REQ-015 ZERO: gen_key SHALL be 1; if opcode=1, en and zero_rnd SHALL also be 1; next state KEY with round=1.
REQ-016 KEY: key_gen=1, next_rnd=1, r_con_ctrl=rcon[round]; next state DATA if opcode=1; if opcode=0, next state KEY with round+1, or DONE when round=10.
REQ-017 DATA: key_gen=0 and en=1; full_enc=1 for rounds 1-9 and final_rnd=1 for round 10; next state KEY with round+1, or DONE when round=10.
REQ-018 rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex), generated by a GF(2^8) xtime register (shift left, XOR 0x1B on carry-out), not a table.
REQ-019 The rcon register SHALL reload to 0x01 in ZERO.
REQ-020 DONE SHALL assert cipher_ready_o (opcode=1) or key_ready_o (opcode=0) for exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency from the clk edge that samples run_i in IDLE to the ready pulse SHALL be 22 cycles for encrypt and 12 cycles for key expansion.
REQ-022 run_i and opcode_i SHALL be ignored outside IDLE.
REQ-023 When run_i is held high, a new operation SHALL start from IDLE, giving at least one IDLE cycle between operations.
REQ-024 rnd_o SHALL never exceed 10, and the counter SHALL reset to 0 in IDLE.
REQ-025 At most one of zero_rnd, full_enc and final_rnd SHALL be 1 in any cycle.
REQ-026 key_ready_o and cipher_ready_o SHALL never be asserted together.

Reset
REQ-027 With nrst=0 at a clk edge, the state SHALL become IDLE, round 0, rcon register 0x01, latched opcode 0, and every output 0 (r_con_ctrl 0x00) in the following cycle.
REQ-028 A reset mid-operation SHALL abort it, with no ready pulse.
REQ-029 The block SHALL have no asynchronous reset path.

Configuration
REQ-030 The macro AES_CTRL_ABORT_EN SHALL control an abort feature.
REQ-031 With AES_CTRL_ABORT_EN defined, an input abort_i (1 bit) SHALL exist; abort_i=1 in ZERO, KEY or DATA SHALL force IDLE at the next edge, with outputs 0 and no ready pulse.
REQ-032 With AES_CTRL_ABORT_EN defined, abort_i SHALL be ignored in IDLE and DONE, and abort_i SHALL take priority over run_i.
REQ-033 Without AES_CTRL_ABORT_EN, the abort_i port SHALL be absent and behaviour SHALL be as in REQ-013 to REQ-026.

Verification
REQ-034 Encrypt: reset, then run_i=1 with opcode_i=1 for one cycle -> zero_rnd one cycle, then 10 KEY/DATA pairs, full_enc 9 times, final_rnd once with rnd_o=10, cipher_ready_o exactly 22 cycles after the run edge.
REQ-035 Key-only: opcode_i=0 -> en never 1, r_con_ctrl sequence 01,02,04,08,10,20,40,80,1B,36 on consecutive cycles, key_ready_o 12 cycles after the run edge.
REQ-036 Busy ignore: run_i toggled and opcode_i flipped during DATA round 5 -> run unaffected, single cipher_ready_o at cycle 22.
REQ-037 Back-to-back: run_i held high through two operations -> second zero_rnd exactly 2 cycles after the first cipher_ready_o cycle, with rcon restarting at 0x01.
REQ-038 Mid-run reset: nrst=0 during KEY round 7 -> all outputs 0 and rnd_o=0 next cycle, no ready pulse; a subsequent run completes normally.
REQ-039 With AES_CTRL_ABORT_EN defined: abort_i=1 in DATA round 3 -> IDLE next cycle, no cipher_ready_o; abort_i=1 in IDLE together with run_i=1 -> stays IDLE.

Source files
------------

// File: rtl/aes_ctrl.sv
// AES-128 round sequencer: drives aes_enc / aes_key_gen / aes_sbox through ZERO, KEY/DATA x10, DONE.
// Optional macro AES_CTRL_ABORT_EN adds an abort_i input that cancels a running operation.
package aes_pkg;
    typedef logic [7:0] aes_byte;
endpackage

module aes_ctrl (
    input  logic             clk,
    input  logic             nrst,
    input  logic             run_i,
    input  logic             opcode_i,
`ifdef AES_CTRL_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             en,
    output logic             gen_key,
    output logic             next_rnd,
    output aes_pkg::aes_byte r_con_ctrl,
    output logic             key_gen,
    output logic             zero_rnd,
    output logic             full_enc,
    output logic             final_rnd,
    output logic [3:0]       rnd_o,
    output logic             key_ready_o,
    output logic             cipher_ready_o
);
    typedef enum logic [2:0] {IDLE, ZERO, KEY, DATA, DONE} state_t;

    state_t           state_q;
    logic [3:0]       round_q;
    aes_pkg::aes_byte rcon_q;
    aes_pkg::aes_byte rcon_d;
    logic             opcode_q;
    logic             abort;

`ifdef AES_CTRL_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // GF(2^8) xtime: multiply the round constant by x modulo the AES polynomial
    assign rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            round_q  <= 4'd0;
            rcon_q   <= 8'h01;
            opcode_q <= 1'b0;
        end else if (abort && (state_q == ZERO || state_q == KEY || state_q == DATA)) begin
            state_q <= IDLE;
            round_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    round_q <= 4'd0;
                    if (run_i && !abort) begin
                        state_q  <= ZERO;
                        opcode_q <= opcode_i;
                    end
                end
                ZERO: begin
                    state_q <= KEY;
                    round_q <= 4'd1;
                    rcon_q  <= 8'h01;
                end
                KEY: begin
                    rcon_q <= rcon_d;
                    if (opcode_q) begin
                        state_q <= DATA;
                    end else if (round_q == 4'd10) begin
                        state_q <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                DATA: begin
                    if (round_q == 4'd10) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= KEY;
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    round_q <= 4'd0;
                end
                default: begin
                    state_q <= IDLE;
                    round_q <= 4'd0;
                end
            endcase
        end
    end

    // Every output is a pure decode of the registered state, round and opcode
    always_comb begin
        en             = 1'b0;
        gen_key        = 1'b0;
        next_rnd       = 1'b0;
        r_con_ctrl     = 8'h00;
        key_gen        = 1'b0;
        zero_rnd       = 1'b0;
        full_enc       = 1'b0;
        final_rnd      = 1'b0;
        key_ready_o    = 1'b0;
        cipher_ready_o = 1'b0;
        case (state_q)
            ZERO: begin
                gen_key  = 1'b1;
                en       = opcode_q;
                zero_rnd = opcode_q;
            end
            KEY: begin
                key_gen    = 1'b1;
                next_rnd   = 1'b1;
                r_con_ctrl = rcon_q;
            end
            DATA: begin
                en        = 1'b1;
                full_enc  = (round_q != 4'd10);
                final_rnd = (round_q == 4'd10);
            end
            DONE: begin
                cipher_ready_o = opcode_q;
                key_ready_o    = !opcode_q;
            end
            default: ;
        endcase
    end

    assign rnd_o = round_q;
endmodule
